dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the word-addressed data memory. It takes byte-addressed load/store requests from two requesters, port 0 (core load/store path) and port 1 (debug/DMA path), over a valid/ready handshake. It grants them round-robin and drives the memory's active-low chip select, write enable, byte mask, word address and write data. Each accepted request gets a one-cycle response pulse carrying read data or an error flag.

## Interface
- REG_SIZE, 32: data/address width.
- MEM_SIZE_IN_KB, 1: memory size; must match the attached data memory.
- NO_OF_REGS, MEM_SIZE_IN_KB*1024/4: number of words; derived, not overridden.
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- reqN_valid_i  in  1  request present (N = 0, 1; all reqN_/rspN_ ports exist per port).
- reqN_ready_o  out  1  request accepted this cycle when high with valid.
- reqN_we_i  in  1  1 = store, 0 = load.
- reqN_addr_i  in  REG_SIZE  byte address.
- reqN_mask_i  in  4  byte enables for stores; ignored for loads.
- reqN_wdata_i  in  REG_SIZE  store data.
- rspN_valid_o  out  1  one-cycle response pulse.
- rspN_rdata_o  out  REG_SIZE  load data; 0 for stores and errors.
- rspN_err_o  out  1  misaligned or out-of-range access; valid with rspN_valid_o.
- mem_cs_o  out  1  memory chip select, active-low.
- mem_we_o  out  1  memory write enable.
- mem_mask_o  out  4  memory byte mask.
- mem_addr_o  out  REG_SIZE  word index (byte address >> 2, zero-extended).
- mem_wdata_o  out  REG_SIZE  memory write data.
- mem_rdata_i  in  REG_SIZE  memory read data, combinational from mem_addr_o.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - reqN_ready_o = 1 only for the requester selected this cycle; ready is combinational from valid and the priority pointer.
  - On handshake, latch port id, we, addr, mask, wdata.
  - Check the latched request: error if addr[1:0] != 0, or if addr>>2 >= NO_OF_REGS. Error goes to RESP; otherwise go to ACCESS.
- Arbitration:
  - If only one port is valid, it wins.
  - If both are valid, the port not granted last wins. Pointer last_grant resets to 1, so port 0 wins the first tie.
  - last_grant updates on every handshake, including erroring ones.
- ACCESS (one cycle):
  - mem_cs_o = 0; mem_addr_o, mem_mask_o and mem_wdata_o come from the latched request; mem_we_o = latched we.
  - For a store, memory writes at the closing edge. For a load, mem_rdata_i is captured into the response register at that edge; mask is driven but irrelevant.
  - Next state RESP.
- RESP (one cycle):
  - rspN_valid_o = 1 for the latched port only.
  - rdata is the captured word for a good load, else 0. err_o is set on the error path.
  - Next state IDLE.
- Outside ACCESS: mem_cs_o = 1, mem_we_o = 0, mem_mask_o = 0; address and wdata hold their last values.
- A requester must hold valid and payload stable until ready. Dropping valid before ready withdraws the request harmlessly.

## Timing
- Reset values (asynchronous, while rst_ni = 0):
  - state IDLE; all ready, rsp valid and err outputs 0; rdata 0.
  - mem_cs_o 1, mem_we_o 0, mem_mask_o 0, mem_addr_o 0, mem_wdata_o 0.
- Good access: handshake in cycle T, ACCESS in T+1 (store written at end of T+1), rsp valid in T+2.
- Error access: handshake in T, rsp valid with err in T+1; the memory is never selected.
- Throughput: one request per 3 cycles (2 on the error path). ready is 0 in ACCESS and RESP.
- Simultaneous valids in IDLE: exactly one ready is high. The loser keeps valid asserted and is granted in the next IDLE cycle.
- Reset asserted mid-ACCESS: mem_cs_o and mem_we_o deassert immediately, the store is not guaranteed, and no response is issued.
- Address wrap: addr near 2^32 gives a word index >= NO_OF_REGS, which is an error; no modular wrap into memory.

## Test plan
- Port 0 stores addr 0x10, mask 4'b1111, wdata 0xDEADBEEF; then loads 0x10. Required: store rsp at T+2 with err 0 and rdata 0; mem_addr_o = 4 during ACCESS; load rsp0_rdata_o = 0xDEADBEEF.
- Port 1 stores mask 4'b0010, wdata 0x0000AB00 to addr 0x10, then loads 0x10. Required: mem_mask_o = 4'b0010 in ACCESS; read returns 0xDEADABEF.
- Both ports valid continuously from reset, 4 requests each. Required: grants alternate 0,1,0,1,...; each port gets exactly 4 responses; no two responses in the same cycle.
- Load addr 0x12, then load addr 0x400 (NO_OF_REGS = 256). Required: each responds 1 cycle after handshake with err 1 and rdata 0; mem_cs_o stays 1.
- rst_ni pulled low during ACCESS of a store. Required: mem_cs_o = 1 and mem_we_o = 0 in the same cycle; no rsp pulse. After release, first tie goes to port 0.
- Port 0 asserts valid for 1 cycle while in RESP, then drops it. Required: no ready, no response, no memory access for that request.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the word-addressed data memory.
// Each accepted request runs IDLE -> ACCESS -> RESP (or IDLE -> RESP on an address error).
module dmem_arbiter #(
  parameter int REG_SIZE       = 32,
  parameter int MEM_SIZE_IN_KB = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic                req0_we_i,
  input  logic [REG_SIZE-1:0] req0_addr_i,
  input  logic [3:0]          req0_mask_i,
  input  logic [REG_SIZE-1:0] req0_wdata_i,
  output logic                rsp0_valid_o,
  output logic [REG_SIZE-1:0] rsp0_rdata_o,
  output logic                rsp0_err_o,

  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic                req1_we_i,
  input  logic [REG_SIZE-1:0] req1_addr_i,
  input  logic [3:0]          req1_mask_i,
  input  logic [REG_SIZE-1:0] req1_wdata_i,
  output logic                rsp1_valid_o,
  output logic [REG_SIZE-1:0] rsp1_rdata_o,
  output logic                rsp1_err_o,

  output logic                mem_cs_o,
  output logic                mem_we_o,
  output logic [3:0]          mem_mask_o,
  output logic [REG_SIZE-1:0] mem_addr_o,
  output logic [REG_SIZE-1:0] mem_wdata_o,
  input  logic [REG_SIZE-1:0] mem_rdata_i
);

  localparam int NO_OF_REGS = MEM_SIZE_IN_KB * 1024 / 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  state_t              state_next;

  logic                last_grant;
  logic                grant0;
  logic                grant1;
  logic                handshake;

  logic                sel_we;
  logic [REG_SIZE-1:0] sel_addr;
  logic [3:0]          sel_mask;
  logic [REG_SIZE-1:0] sel_wdata;
  logic                sel_err;

  logic                port_p0;
  logic                we_p0;
  logic                err_p0;
  logic [3:0]          mask_p0;
  logic [REG_SIZE-1:0] word_p0;
  logic [REG_SIZE-1:0] wdata_p0;
  logic [REG_SIZE-1:0] rdata_p1;

  logic                rsp0_vld;
  logic                rsp1_vld;

  // Misaligned or beyond the last word; no modular wrap of high addresses.
  function automatic logic addr_err(input logic [REG_SIZE-1:0] addr);
    logic [REG_SIZE-1:0] word;
    word     = addr >> 2;
    addr_err = (addr[1:0] != 2'b00) || (word >= REG_SIZE'(NO_OF_REGS));
  endfunction

  // Tie goes to the port not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid_i && (!req1_valid_i || last_grant))
        grant0 = 1'b1;
      else if (req1_valid_i)
        grant1 = 1'b1;
    end
  end

  assign handshake    = grant0 | grant1;
  assign req0_ready_o = grant0 & rst_ni;
  assign req1_ready_o = grant1 & rst_ni;

  always_comb begin
    sel_we    = grant1 ? req1_we_i    : req0_we_i;
    sel_addr  = grant1 ? req1_addr_i  : req0_addr_i;
    sel_mask  = grant1 ? req1_mask_i  : req0_mask_i;
    sel_wdata = grant1 ? req1_wdata_i : req0_wdata_i;
    sel_err   = addr_err(sel_addr);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (handshake) state_next = sel_err ? RESP : ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_cs_o   = 1'b1;
    mem_we_o   = 1'b0;
    mem_mask_o = 4'b0000;
    rsp0_vld   = 1'b0;
    rsp1_vld   = 1'b0;
    unique case (state)
      ACCESS: begin
        mem_cs_o   = 1'b0;
        mem_we_o   = we_p0;
        mem_mask_o = mask_p0;
      end
      RESP: begin
        rsp0_vld = ~port_p0;
        rsp1_vld = port_p0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_grant <= 1'b1;
    else if (handshake) last_grant <= grant1;
  end

  // Stage p0: request captured at handshake; memory-side fields only change on good requests
  // so mem_addr_o and mem_wdata_o hold the last real access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      port_p0  <= 1'b0;
      we_p0    <= 1'b0;
      err_p0   <= 1'b0;
      mask_p0  <= '0;
      word_p0  <= '0;
      wdata_p0 <= '0;
    end else if (handshake) begin
      port_p0 <= grant1;
      we_p0   <= sel_we;
      err_p0  <= sel_err;
      if (!sel_err) begin
        mask_p0  <= sel_mask;
        word_p0  <= {2'b00, sel_addr[REG_SIZE-1:2]};
        wdata_p0 <= sel_wdata;
      end
    end
  end

  // Stage p1: load data captured at the edge closing ACCESS.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      rdata_p1 <= '0;
    else if (handshake)
      rdata_p1 <= '0;
    else if (state == ACCESS && !we_p0)
      rdata_p1 <= mem_rdata_i;
  end

  assign mem_addr_o  = word_p0;
  assign mem_wdata_o = wdata_p0;

  assign rsp0_valid_o = rsp0_vld;
  assign rsp1_valid_o = rsp1_vld;
  assign rsp0_err_o   = rsp0_vld & err_p0;
  assign rsp1_err_o   = rsp1_vld & err_p0;
  assign rsp0_rdata_o = rsp0_vld ? rdata_p1 : '0;
  assign rsp1_rdata_o = rsp1_vld ? rdata_p1 : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-maskable 256-word memory attached.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic [3:0]  req0_mask;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wdata;
  logic [3:0]  req1_mask;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        mem_cs, mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  bit   [31:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.REG_SIZE(32), .MEM_SIZE_IN_KB(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_we_i(req0_we),
    .req0_addr_i(req0_addr), .req0_mask_i(req0_mask), .req0_wdata_i(req0_wdata),
    .rsp0_valid_o(rsp0_valid), .rsp0_rdata_o(rsp0_rdata), .rsp0_err_o(rsp0_err),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_we_i(req1_we),
    .req1_addr_i(req1_addr), .req1_mask_i(req1_mask), .req1_wdata_i(req1_wdata),
    .rsp1_valid_o(rsp1_valid), .rsp1_rdata_o(rsp1_rdata), .rsp1_err_o(rsp1_err),
    .mem_cs_o(mem_cs), .mem_we_o(mem_we), .mem_mask_o(mem_mask),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (!mem_cs && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, check it is granted this cycle, then withdraw after the edge.
  task automatic issue(input int port, input logic we, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] wdata, input string tag);
    if (port == 0) begin
      req0_we = we; req0_addr = addr; req0_mask = mask; req0_wdata = wdata; req0_valid = 1'b1;
    end else begin
      req1_we = we; req1_addr = addr; req1_mask = mask; req1_wdata = wdata; req1_valid = 1'b1;
    end
    #1;
    chk({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, (port == 0) ? 32'd1 : 32'd2);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  int          n0, n1, ngrant, overlap, both_ready;
  logic [7:0]  grant_seq;
  logic        g0, g1;

  initial begin
    rst_ni = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_mask = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_mask = '0; req1_wdata = '0;
    #2;
    req0_valid = 1'b1;
    #1;
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_cs", {31'd0, mem_cs}, 32'd1);
    chk("rst_we_mask", {27'd0, mem_we, mem_mask}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rsp", {28'd0, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err}, 32'd0);
    chk("rst_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
    req0_valid = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // Port 0 full-word store, then load back.
    issue(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, "st0");
    chk("st0_acc_cs", {31'd0, mem_cs}, 32'd0);
    chk("st0_acc_we", {31'd0, mem_we}, 32'd1);
    chk("st0_acc_addr", mem_addr, 32'd4);
    chk("st0_acc_mask", {28'd0, mem_mask}, 32'hF);
    chk("st0_acc_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st0_acc_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    chk("st0_rsp", {29'd0, rsp0_valid, rsp0_err, rsp1_valid}, 32'b100);
    chk("st0_rsp_rdata", rsp0_rdata, 32'd0);
    chk("st0_rsp_cs", {31'd0, mem_cs}, 32'd1);
    tick();
    chk("st0_idle_rsp", {31'd0, rsp0_valid}, 32'd0);

    issue(0, 1'b0, 32'h10, 4'b0000, 32'h0, "ld0");
    chk("ld0_acc", {30'd0, mem_cs, mem_we}, 32'd0);
    tick();
    chk("ld0_rsp", {29'd0, rsp0_valid, rsp0_err, rsp1_valid}, 32'b100);
    chk("ld0_rdata", rsp0_rdata, 32'hDEADBEEF);
    // A request shown only during RESP and dropped must leave no trace.
    req0_we = 1'b1; req0_addr = 32'h20; req0_mask = 4'hF; req0_wdata = 32'h55AA55AA;
    req0_valid = 1'b1;
    #1;
    chk("drop_ready_resp", {31'd0, req0_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("drop_ready_idle", {31'd0, req0_ready}, 32'd0);
    tick();
    chk("drop_cs1", {30'd0, mem_cs, rsp0_valid}, 32'b10);
    tick();
    chk("drop_cs2", {30'd0, mem_cs, rsp0_valid}, 32'b10);

    // Port 1 byte-lane store merges into the existing word.
    issue(1, 1'b1, 32'h10, 4'b0010, 32'h0000AB00, "st1");
    chk("st1_acc_mask", {28'd0, mem_mask}, 32'b0010);
    chk("st1_acc_addr", mem_addr, 32'd4);
    tick();
    chk("st1_rsp", {29'd0, rsp1_valid, rsp1_err, rsp0_valid}, 32'b100);
    chk("st1_rsp_rdata", rsp1_rdata, 32'd0);
    tick();
    issue(1, 1'b0, 32'h10, 4'b0000, 32'h0, "ld1");
    tick();
    chk("ld1_rsp", {29'd0, rsp1_valid, rsp1_err, rsp0_valid}, 32'b100);
    chk("ld1_rdata", rsp1_rdata, 32'hDEADABEF);
    tick();

    // Error path: response one cycle after handshake, memory untouched.
    issue(0, 1'b0, 32'h12, 4'b0000, 32'h0, "mis");
    chk("mis_rsp", {29'd0, rsp0_valid, rsp0_err, mem_cs}, 32'b111);
    chk("mis_rdata", rsp0_rdata, 32'd0);
    tick();
    chk("mis_idle", {30'd0, rsp0_valid, mem_cs}, 32'b01);
    issue(0, 1'b0, 32'h400, 4'b0000, 32'h0, "oor");
    chk("oor_rsp", {29'd0, rsp0_valid, rsp0_err, mem_cs}, 32'b111);
    chk("oor_rdata", rsp0_rdata, 32'd0);
    tick();
    issue(1, 1'b0, 32'hFFFFFFFC, 4'b0000, 32'h0, "wrap");
    chk("wrap_rsp", {29'd0, rsp1_valid, rsp1_err, mem_cs}, 32'b111);
    chk("wrap_rdata", rsp1_rdata, 32'd0);
    tick();

    // Reset during a store ACCESS.
    issue(0, 1'b1, 32'h30, 4'b1111, 32'h12345678, "rst_st");
    chk("rst_st_acc", {30'd0, mem_cs, mem_we}, 32'b01);
    rst_ni = 1'b0;
    #1;
    chk("rst_st_cs_we", {30'd0, mem_cs, mem_we}, 32'b10);
    tick();
    chk("rst_st_norsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);

    // Both ports valid continuously from reset release, four loads each.
    req0_we = 1'b0; req0_addr = 32'h10; req0_mask = '0; req0_wdata = '0;
    req1_we = 1'b0; req1_addr = 32'h10; req1_mask = '0; req1_wdata = '0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("tie_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    rst_ni = 1'b1;
    n0 = 0; n1 = 0; ngrant = 0; overlap = 0; both_ready = 0; grant_seq = '0;
    for (int c = 0; c < 60 && (n0 < 4 || n1 < 4); c++) begin
      #1;
      g0 = req0_ready;
      g1 = req1_ready;
      if (g0 && g1) both_ready++;
      if (g0 || g1) begin
        grant_seq = {grant_seq[6:0], g1};
        ngrant++;
      end
      tick();
      if (g0 && ngrant >= 7) req0_valid = 1'b0;
      if (g1 && ngrant >= 8) req1_valid = 1'b0;
      if (rsp0_valid && rsp1_valid) overlap++;
      if (rsp0_valid) begin
        n0++;
        chk("tie_rdata0", rsp0_rdata, 32'hDEADABEF);
      end
      if (rsp1_valid) begin
        n1++;
        chk("tie_rdata1", rsp1_rdata, 32'hDEADABEF);
      end
    end
    chk("tie_grants", ngrant, 32'd8);
    chk("tie_order", {24'd0, grant_seq}, 32'h55);
    chk("tie_n0", n0, 32'd4);
    chk("tie_n1", n1, 32'd4);
    chk("tie_overlap", overlap, 32'd0);
    chk("tie_both_ready", both_ready, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
